// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg
//   Shared types and encodings for the LC-3 control unit: FSM state enum,
//   opcode values and the select encodings driven onto the datapath muxes.
//   The pause states exist only when LC3_PAUSE_EN is defined.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    S_HALTED   = 5'd0,
    S_FETCH    = 5'd1,
    S_FETCH_RD = 5'd2,
    S_IR_LD    = 5'd3,
    S_DECODE   = 5'd4,
    S_ALU_EX   = 5'd5,
    S_BR_CHK   = 5'd6,
    S_BR_TAKE  = 5'd7,
    S_JMP_EX   = 5'd8,
    S_JSR_R7   = 5'd9,
    S_JSR_PC   = 5'd10,
    S_JSRR_PC  = 5'd11,
    S_MAR_LD   = 5'd12,
    S_LD_RD    = 5'd13,
    S_LD_WB    = 5'd14,
    S_MAR_ST   = 5'd15,
    S_ST_MDR   = 5'd16,
    S_ST_WR    = 5'd17,
    S_LEA_EX   = 5'd18,
    S_NOP_EX   = 5'd19
`ifdef LC3_PAUSE_EN
    ,
    S_PAUSE1   = 5'd20,
    S_PAUSE2   = 5'd21
`endif
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LD    = 4'b0010;
  localparam logic [3:0] OP_ST    = 4'b0011;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;
  localparam logic [3:0] OP_LEA   = 4'b1110;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic DRMUX_IR = 1'b0;
  localparam logic DRMUX_R7 = 1'b1;

endpackage

// File: rtl/lc3_control_unit_timer.sv
// mem_wait_timer
//   Wait-state counter shared by every SRAM access state. A start pulse in the
//   cycle before an access loads MEM_WAIT-1; the count then runs down once per
//   cycle while the access is active, so an access lasts exactly MEM_WAIT cycles.
// Ports
//   clk_i     clock
//   rst_ni    synchronous active-low reset
//   start_i   begin a new access on the next edge
//   active_o  an access is in progress this cycle
//   last_o    this is the final cycle of the access
module mem_wait_timer #(
  parameter int MEM_WAIT = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic active_o,
  output logic last_o
);

  localparam logic [3:0] LOAD = 4'(MEM_WAIT - 1);

  logic [3:0] count_q;
  logic       active_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= 4'd0;
      active_q <= 1'b0;
    end else if (start_i) begin
      count_q  <= LOAD;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (count_q == 4'd0) active_q <= 1'b0;
      else                 count_q  <= count_q - 4'd1;
    end
  end

  assign active_o = active_q;
  assign last_o   = active_q && (count_q == 4'd0);

endmodule

// File: rtl/lc3_control_unit.sv
// lc3_control_unit
//   LC-3 control FSM. Sequences fetch/decode/execute and drives the datapath
//   load, gate and mux-select strobes plus the SRAM OE/WE strobes. SRAM wait
//   states come from one shared mem_wait_timer (MEM_WAIT cycles per access).
//   Optional: define LC3_PAUSE_EN to make opcode 1101 a pause instruction
//   (LED load, then wait for Continue to go high and low again).
// Ports
//   Clk, Reset_n (sync, active-low), Run, Continue  control inputs
//   Opcode, IR_5, IR_11, BEN                        decode inputs from datapath
//   LD_*, Gate*, *MUX, ALUK                         datapath controls
//   Mem_OE, Mem_WE                                  SRAM strobes (active-high)
//   Instr_done                                      pulse in last exec cycle
//   state_o                                         current FSM state (debug)
module lc3_control_unit
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Instr_done,
  output logic [4:0] state_o
);

  state_t state_q, state_d;
  logic   mem_start, tmr_active, tmr_last;

  mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .start_i  (mem_start),
    .active_o (tmr_active),
    .last_o   (tmr_last)
  );

`ifdef LC3_PAUSE_EN
  // Marks the first PAUSE1 cycle so the LED register loads only once.
  logic pause_entry_q;
  always_ff @(posedge Clk) begin
    if (!Reset_n) pause_entry_q <= 1'b0;
    else          pause_entry_q <= (state_d == S_PAUSE1) && (state_q != S_PAUSE1);
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= S_HALTED;
    else          state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    state_d    = state_q;
    mem_start  = 1'b0;
    LD_MAR     = 1'b0;  LD_MDR  = 1'b0;  LD_IR   = 1'b0;  LD_BEN     = 1'b0;
    LD_CC      = 1'b0;  LD_REG  = 1'b0;  LD_PC   = 1'b0;  LD_LED     = 1'b0;
    GatePC     = 1'b0;  GateMDR = 1'b0;  GateALU = 1'b0;  GateMARMUX = 1'b0;
    PCMUX      = PCMUX_PC1;
    DRMUX      = DRMUX_IR;
    SR1MUX     = 1'b0;  SR2MUX  = 1'b0;  ADDR1MUX = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    ALUK       = ALUK_ADD;
    Mem_OE     = 1'b0;  Mem_WE  = 1'b0;  Instr_done = 1'b0;

    case (state_q)
      S_HALTED: if (Run) state_d = S_FETCH;
      S_FETCH: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_PC1;
        mem_start = 1'b1;
        state_d = S_FETCH_RD;
      end
      S_FETCH_RD: begin
        Mem_OE = tmr_active;
        LD_MDR = tmr_last;
        if (tmr_last) state_d = S_IR_LD;
      end
      S_IR_LD: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD, OP_AND, OP_NOT: state_d = S_ALU_EX;
          OP_BR:                  state_d = S_BR_CHK;
          OP_JMP:                 state_d = S_JMP_EX;
          OP_JSR:                 state_d = S_JSR_R7;
          OP_LDR, OP_LD:          state_d = S_MAR_LD;
          OP_STR, OP_ST:          state_d = S_MAR_ST;
          OP_LEA:                 state_d = S_LEA_EX;
`ifdef LC3_PAUSE_EN
          OP_PAUSE:               state_d = S_PAUSE1;
`endif
          default:                state_d = S_NOP_EX;
        endcase
      end
      S_ALU_EX: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = 1'b1; SR2MUX = IR_5;
        ALUK = (Opcode == OP_AND) ? ALUK_AND : (Opcode == OP_NOT) ? ALUK_NOT : ALUK_ADD;
        Instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_BR_CHK: begin
        if (BEN) state_d = S_BR_TAKE;
        else begin
          Instr_done = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BR_TAKE: begin
        LD_PC = 1'b1; PCMUX = PCMUX_ADDER; ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF9;
        Instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_JMP_EX, S_JSRR_PC: begin
        SR1MUX = 1'b1; ALUK = ALUK_PASSA; GateALU = 1'b1; PCMUX = PCMUX_BUS; LD_PC = 1'b1;
        Instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_JSR_R7: begin
        // R7 <- PC (already incremented); IR is stable here so IR_11 is valid.
        GatePC = 1'b1; DRMUX = DRMUX_R7; LD_REG = 1'b1;
        state_d = IR_11 ? S_JSR_PC : S_JSRR_PC;
      end
      S_JSR_PC: begin
        LD_PC = 1'b1; PCMUX = PCMUX_ADDER; ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF11;
        Instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_MAR_LD, S_MAR_ST: begin
        // Opcode bit 2 separates base+off6 (LDR/STR) from PC+off9 (LD/ST).
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
        SR1MUX   = Opcode[2];
        ADDR1MUX = Opcode[2];
        ADDR2MUX = Opcode[2] ? ADDR2_OFF6 : ADDR2_OFF9;
        if (state_q == S_MAR_LD) begin
          mem_start = 1'b1;
          state_d = S_LD_RD;
        end else begin
          state_d = S_ST_MDR;
        end
      end
      S_LD_RD: begin
        Mem_OE = tmr_active;
        LD_MDR = tmr_last;
        if (tmr_last) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        Instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_ST_MDR: begin
        SR1MUX = 1'b0; ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1;
        mem_start = 1'b1;
        state_d = S_ST_WR;
      end
      S_ST_WR: begin
        Mem_WE = tmr_active;
        Instr_done = tmr_last;
        if (tmr_last) state_d = S_FETCH;
      end
      S_LEA_EX: begin
        ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF9; GateMARMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        Instr_done = 1'b1;
        state_d = S_FETCH;
      end
`ifdef LC3_PAUSE_EN
      S_PAUSE1: begin
        LD_LED = pause_entry_q;
        if (Continue) state_d = S_PAUSE2;
      end
      S_PAUSE2: begin
        if (!Continue) begin
          Instr_done = 1'b1;
          state_d = S_FETCH;
        end
      end
`endif
      S_NOP_EX: begin
        Instr_done = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_HALTED;
    endcase
  end

`ifndef LC3_PAUSE_EN
  // Continue only matters for the pause instruction.
  logic unused_continue;
  assign unused_continue = Continue;
`endif

endmodule

// File: tb/tb_lc3_control_unit.sv
// tb_lc3_control_unit
//   Directed bench for lc3_control_unit. Main instance uses MEM_WAIT=3; two
//   small instances with MEM_WAIT=1 and 5 run an ADD to check access length.
//   Control outputs are packed into one vector per instance:
//   [25]LD_MAR [24]LD_MDR [23]LD_IR [22]LD_BEN [21]LD_CC [20]LD_REG [19]LD_PC
//   [18]LD_LED [17]GatePC [16]GateMDR [15]GateALU [14]GateMARMUX [13:12]PCMUX
//   [11]DRMUX [10]SR1MUX [9]SR2MUX [8]ADDR1MUX [7:6]ADDR2MUX [5:4]ALUK
//   [3]Mem_OE [2]Mem_WE [1]Instr_done [0]unused(0)
module tb_lc3_control_unit;
  import lc3_ctrl_pkg::*;

  typedef logic [25:0] ctl_t;
  localparam ctl_t M_LD_MAR  = ctl_t'(1) << 25;
  localparam ctl_t M_LD_MDR  = ctl_t'(1) << 24;
  localparam ctl_t M_LD_IR   = ctl_t'(1) << 23;
  localparam ctl_t M_LD_BEN  = ctl_t'(1) << 22;
  localparam ctl_t M_LD_CC   = ctl_t'(1) << 21;
  localparam ctl_t M_LD_REG  = ctl_t'(1) << 20;
  localparam ctl_t M_LD_PC   = ctl_t'(1) << 19;
  localparam ctl_t M_LD_LED  = ctl_t'(1) << 18;
  localparam ctl_t M_GPC     = ctl_t'(1) << 17;
  localparam ctl_t M_GMDR    = ctl_t'(1) << 16;
  localparam ctl_t M_GALU    = ctl_t'(1) << 15;
  localparam ctl_t M_GMARMUX = ctl_t'(1) << 14;
  localparam ctl_t M_PC_BUS  = ctl_t'(1) << 12;
  localparam ctl_t M_PC_ADD  = ctl_t'(2) << 12;
  localparam ctl_t M_DRMUX   = ctl_t'(1) << 11;
  localparam ctl_t M_SR1     = ctl_t'(1) << 10;
  localparam ctl_t M_SR2     = ctl_t'(1) << 9;
  localparam ctl_t M_A1      = ctl_t'(1) << 8;
  localparam ctl_t M_A2_OFF6 = ctl_t'(1) << 6;
  localparam ctl_t M_A2_OFF9 = ctl_t'(2) << 6;
  localparam ctl_t M_A2_OFF11= ctl_t'(3) << 6;
  localparam ctl_t M_K_AND   = ctl_t'(1) << 4;
  localparam ctl_t M_K_NOT   = ctl_t'(2) << 4;
  localparam ctl_t M_K_PASSA = ctl_t'(3) << 4;
  localparam ctl_t M_OE      = ctl_t'(1) << 3;
  localparam ctl_t M_WE      = ctl_t'(1) << 2;
  localparam ctl_t M_DONE    = ctl_t'(1) << 1;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n = 1'b0, Run = 1'b0, Continue = 1'b0;
  logic [3:0] Opcode = 4'b0000;
  logic       IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
  logic       a_rst_n = 1'b0, run1 = 1'b0, run5 = 1'b0;
  logic [3:0] op_add = 4'b0001;
  logic       one = 1'b1, zero = 1'b0;

  ctl_t obs, o1, o5;
  logic [4:0] st, st1, st5;
  assign obs[0] = 1'b0;
  assign o1[0]  = 1'b0;
  assign o5[0]  = 1'b0;

  lc3_control_unit #(.MEM_WAIT(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(obs[25]), .LD_MDR(obs[24]), .LD_IR(obs[23]), .LD_BEN(obs[22]),
    .LD_CC(obs[21]), .LD_REG(obs[20]), .LD_PC(obs[19]), .LD_LED(obs[18]),
    .GatePC(obs[17]), .GateMDR(obs[16]), .GateALU(obs[15]), .GateMARMUX(obs[14]),
    .PCMUX(obs[13:12]), .DRMUX(obs[11]), .SR1MUX(obs[10]), .SR2MUX(obs[9]),
    .ADDR1MUX(obs[8]), .ADDR2MUX(obs[7:6]), .ALUK(obs[5:4]),
    .Mem_OE(obs[3]), .Mem_WE(obs[2]), .Instr_done(obs[1]), .state_o(st)
  );

  lc3_control_unit #(.MEM_WAIT(1)) dut_w1 (
    .Clk(Clk), .Reset_n(a_rst_n), .Run(run1), .Continue(zero),
    .Opcode(op_add), .IR_5(one), .IR_11(zero), .BEN(zero),
    .LD_MAR(o1[25]), .LD_MDR(o1[24]), .LD_IR(o1[23]), .LD_BEN(o1[22]),
    .LD_CC(o1[21]), .LD_REG(o1[20]), .LD_PC(o1[19]), .LD_LED(o1[18]),
    .GatePC(o1[17]), .GateMDR(o1[16]), .GateALU(o1[15]), .GateMARMUX(o1[14]),
    .PCMUX(o1[13:12]), .DRMUX(o1[11]), .SR1MUX(o1[10]), .SR2MUX(o1[9]),
    .ADDR1MUX(o1[8]), .ADDR2MUX(o1[7:6]), .ALUK(o1[5:4]),
    .Mem_OE(o1[3]), .Mem_WE(o1[2]), .Instr_done(o1[1]), .state_o(st1)
  );

  lc3_control_unit #(.MEM_WAIT(5)) dut_w5 (
    .Clk(Clk), .Reset_n(a_rst_n), .Run(run5), .Continue(zero),
    .Opcode(op_add), .IR_5(one), .IR_11(zero), .BEN(zero),
    .LD_MAR(o5[25]), .LD_MDR(o5[24]), .LD_IR(o5[23]), .LD_BEN(o5[22]),
    .LD_CC(o5[21]), .LD_REG(o5[20]), .LD_PC(o5[19]), .LD_LED(o5[18]),
    .GatePC(o5[17]), .GateMDR(o5[16]), .GateALU(o5[15]), .GateMARMUX(o5[14]),
    .PCMUX(o5[13:12]), .DRMUX(o5[11]), .SR1MUX(o5[10]), .SR2MUX(o5[9]),
    .ADDR1MUX(o5[8]), .ADDR2MUX(o5[7:6]), .ALUK(o5[5:4]),
    .Mem_OE(o5[3]), .Mem_WE(o5[2]), .Instr_done(o5[1]), .state_o(st5)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Walks FETCH, three read cycles, IR_LD and DECODE; leaves the DUT in its
  // first execute state at the sampling point.
  task automatic do_fetch(input string nm, input logic [3:0] op, input logic i5, input logic i11);
    Opcode = op; IR_5 = i5; IR_11 = i11;
    check({nm, "/fetch"}, obs, M_GPC | M_LD_MAR | M_LD_PC);
    check({nm, "/st_fetch"}, st, S_FETCH);
    step();
    for (int i = 0; i < 3; i++) begin
      check({nm, "/fetch_rd"}, obs, (i == 2) ? (M_OE | M_LD_MDR) : M_OE);
      step();
    end
    check({nm, "/ir_ld"}, obs, M_GMDR | M_LD_IR);
    step();
    check({nm, "/decode"}, obs, M_LD_BEN);
    step();
  endtask

  task automatic aux_add(input bit w5, input int n);
    ctl_t v;
    if (w5) run5 = 1'b1; else run1 = 1'b1;
    step();
    run1 = 1'b0; run5 = 1'b0;
    v = w5 ? o5 : o1;
    check(w5 ? "w5/fetch" : "w1/fetch", v, M_GPC | M_LD_MAR | M_LD_PC);
    step();
    for (int i = 0; i < n; i++) begin
      v = w5 ? o5 : o1;
      check(w5 ? "w5/rd" : "w1/rd", v, (i == n - 1) ? (M_OE | M_LD_MDR) : M_OE);
      step();
    end
    v = w5 ? o5 : o1;
    check(w5 ? "w5/ir_ld" : "w1/ir_ld", v, M_GMDR | M_LD_IR);
    step();
    step();
    v = w5 ? o5 : o1;
    check(w5 ? "w5/add_ex" : "w1/add_ex", v,
          M_GALU | M_LD_REG | M_LD_CC | M_SR1 | M_SR2 | M_DONE);
    step();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    step();
    step();
    check("reset/outs", obs, '0);
    check("reset/state", st, S_HALTED);
    Reset_n = 1'b1;
    step();
    check("halted_no_run", st, S_HALTED);
    Run = 1'b1;
    step();
    Run = 1'b0;

    // ADD x1261: imm form
    do_fetch("add", OP_ADD, 1'b1, 1'b0);
    Run = 1'b1;  // ignored outside HALTED
    check("add/ex", obs, M_GALU | M_LD_REG | M_LD_CC | M_SR1 | M_SR2 | M_DONE);
    step();
    Run = 1'b0;
    // AND register form
    do_fetch("and", OP_AND, 1'b0, 1'b0);
    check("and/ex", obs, M_GALU | M_LD_REG | M_LD_CC | M_SR1 | M_K_AND | M_DONE);
    step();
    // NOT
    do_fetch("not", OP_NOT, 1'b1, 1'b0);
    check("not/ex", obs, M_GALU | M_LD_REG | M_LD_CC | M_SR1 | M_SR2 | M_K_NOT | M_DONE);
    step();

    // BR x0402 not taken / taken
    BEN = 1'b0;
    do_fetch("br_nt", OP_BR, 1'b0, 1'b0);
    check("br_nt/chk", obs, M_DONE);
    step();
    BEN = 1'b1;
    do_fetch("br_t", OP_BR, 1'b0, 1'b0);
    check("br_t/chk", obs, '0);
    step();
    check("br_t/take", obs, M_LD_PC | M_PC_ADD | M_A2_OFF9 | M_DONE);
    step();
    BEN = 1'b0;

    // JSR x4805 and JSRR x4080
    do_fetch("jsr", OP_JSR, 1'b0, 1'b1);
    check("jsr/r7", obs, M_GPC | M_DRMUX | M_LD_REG);
    step();
    check("jsr/pc", obs, M_LD_PC | M_PC_ADD | M_A2_OFF11 | M_DONE);
    step();
    do_fetch("jsrr", OP_JSR, 1'b0, 1'b0);
    check("jsrr/r7", obs, M_GPC | M_DRMUX | M_LD_REG);
    step();
    check("jsrr/pc", obs, M_SR1 | M_K_PASSA | M_GALU | M_PC_BUS | M_LD_PC | M_DONE);
    step();

    // JMP
    do_fetch("jmp", OP_JMP, 1'b0, 1'b0);
    check("jmp/ex", obs, M_SR1 | M_K_PASSA | M_GALU | M_PC_BUS | M_LD_PC | M_DONE);
    step();

    // LDR and LD
    do_fetch("ldr", OP_LDR, 1'b0, 1'b0);
    check("ldr/mar", obs, M_GMARMUX | M_LD_MAR | M_SR1 | M_A1 | M_A2_OFF6);
    step();
    for (int i = 0; i < 3; i++) begin
      check("ldr/rd", obs, (i == 2) ? (M_OE | M_LD_MDR) : M_OE);
      step();
    end
    check("ldr/wb", obs, M_GMDR | M_LD_REG | M_LD_CC | M_DONE);
    step();
    do_fetch("ld", OP_LD, 1'b0, 1'b0);
    check("ld/mar", obs, M_GMARMUX | M_LD_MAR | M_A2_OFF9);
    step();
    step(); step(); step();
    check("ld/wb", obs, M_GMDR | M_LD_REG | M_LD_CC | M_DONE);
    step();

    // ST x3403
    do_fetch("st", OP_ST, 1'b0, 1'b0);
    check("st/mar", obs, M_GMARMUX | M_LD_MAR | M_A2_OFF9);
    step();
    check("st/mdr", obs, M_K_PASSA | M_GALU | M_LD_MDR);
    step();
    for (int i = 0; i < 3; i++) begin
      check("st/wr", obs, (i == 2) ? (M_WE | M_DONE) : M_WE);
      step();
    end

    // LEA
    do_fetch("lea", OP_LEA, 1'b0, 1'b0);
    check("lea/ex", obs, M_GMARMUX | M_LD_REG | M_LD_CC | M_A2_OFF9 | M_DONE);
    step();

    // Opcode 1101
    do_fetch("pause", OP_PAUSE, 1'b0, 1'b0);
`ifdef LC3_PAUSE_EN
    check("pause/entry", obs, M_LD_LED);
    step();
    check("pause/hold1", obs, '0);
    Continue = 1'b1;
    step();
    check("pause/hold2", obs, '0);
    step();
    check("pause/still2", st, S_PAUSE2);
    Continue = 1'b0;
    #1;
    check("pause/done", obs, M_DONE);
    step();
`else
    check("pause/nop", obs, M_DONE);
    step();
`endif
    check("after_1101/state", st, S_FETCH);

    // Reset in the middle of an instruction fetch read
    Opcode = OP_ADD;
    step();
    step();
    check("midrst/oe", obs, M_OE);
    Reset_n = 1'b0;
    step();
    check("midrst/outs", obs, '0);
    check("midrst/state", st, S_HALTED);
    Reset_n = 1'b1;
    Run = 1'b1;
    step();
    Run = 1'b0;
    check("midrst/refetch", obs, M_GPC | M_LD_MAR | M_LD_PC);

    // Access length with MEM_WAIT = 1 and 5
    a_rst_n = 1'b1;
    step();
    aux_add(1'b0, 1);
    aux_add(1'b1, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
